// File: rtl/servo_pulse_decoder.sv
// Servo pulse-width decoder: measures the high time of an RC pulse and maps
// 1.0..2.0 ms onto an 8-bit position, rejecting glitches and overlong pulses.
module servo_pulse_decoder #(
  parameter int unsigned MIN_CYCLES     = 25000,
  parameter int unsigned STEP_CYCLES    = 98,
  parameter int unsigned GLITCH_CYCLES  = 12500,
  parameter int unsigned MAX_CYCLES     = 62500,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pulse_in,
  output logic [7:0] pos,
  output logic       pos_valid,
  output logic       pos_strobe,
  output logic       err
);

  localparam logic [19:0] MIN_C    = 20'(MIN_CYCLES);
  localparam logic [19:0] STEP_C   = 20'(STEP_CYCLES);
  localparam logic [19:0] GLITCH_C = 20'(GLITCH_CYCLES);
  localparam logic [19:0] MAX_C    = 20'(MAX_CYCLES);
  localparam logic [19:0] TO_C     = 20'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t      state_r;
  logic [2:0]  sync_r;     // [0],[1] synchronizer, [2] previous synced value
  logic [1:0]  fill_r;     // synchronizer holds genuine samples once both bits set
  logic [19:0] hi_cnt_r;
  logic [19:0] sub_cnt_r;
  logic [19:0] step_cnt_r;
  logic [19:0] to_cnt_r;
  logic [7:0]  pos_r;
  logic        pos_valid_r;
  logic        pos_strobe_r;
  logic        err_r;

  logic synced_s;
  logic rise_s;

  assign synced_s = sync_r[1];
  assign rise_s   = sync_r[1] & ~sync_r[2];

  // Synchronizer, timeout counter and measurement FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= WAIT_LOW;
      sync_r       <= 3'b000;
      fill_r       <= 2'b00;
      hi_cnt_r     <= 20'd0;
      sub_cnt_r    <= 20'd0;
      step_cnt_r   <= 20'd0;
      to_cnt_r     <= 20'd0;
      pos_r        <= 8'd0;
      pos_valid_r  <= 1'b0;
      pos_strobe_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      sync_r       <= {sync_r[1:0], pulse_in};
      fill_r       <= {fill_r[0], 1'b1};
      pos_strobe_r <= 1'b0;
      err_r        <= 1'b0;

      // Timeout runs freely; an accept below overrides it in the same cycle.
      if (to_cnt_r != TO_C) begin
        to_cnt_r <= to_cnt_r + 20'd1;
        if (to_cnt_r == (TO_C - 20'd1)) begin
          pos_valid_r <= 1'b0;
        end else begin
          pos_valid_r <= pos_valid_r;
        end
      end else begin
        to_cnt_r    <= to_cnt_r;
        pos_valid_r <= 1'b0;
      end

      case (state_r)
        WAIT_LOW: begin
          if (fill_r[1] && !synced_s) begin
            state_r <= WAIT_RISE;
          end else begin
            state_r <= WAIT_LOW;
          end
        end

        WAIT_RISE: begin
          if (rise_s) begin
            hi_cnt_r   <= 20'd0;
            sub_cnt_r  <= 20'd0;
            step_cnt_r <= 20'd0;
            state_r    <= MEASURE;
          end else begin
            state_r <= WAIT_RISE;
          end
        end

        MEASURE: begin
          if (synced_s) begin
            hi_cnt_r <= hi_cnt_r + 20'd1;
            if ((hi_cnt_r + 20'd1) == MAX_C) begin
              err_r   <= 1'b1;
              state_r <= WAIT_LOW;
            end else begin
              state_r <= MEASURE;
            end
            if (hi_cnt_r >= MIN_C) begin
              if (sub_cnt_r == (STEP_C - 20'd1)) begin
                sub_cnt_r <= 20'd0;
                if (step_cnt_r != 20'd255) begin
                  step_cnt_r <= step_cnt_r + 20'd1;
                end else begin
                  step_cnt_r <= step_cnt_r;
                end
              end else begin
                sub_cnt_r <= sub_cnt_r + 20'd1;
              end
            end else begin
              sub_cnt_r <= sub_cnt_r;
            end
          end else begin
            if (hi_cnt_r < GLITCH_C) begin
              err_r <= 1'b1;
            end else begin
              pos_r        <= step_cnt_r[7:0];
              pos_strobe_r <= 1'b1;
              pos_valid_r  <= 1'b1;
              to_cnt_r     <= 20'd0;
            end
            state_r <= WAIT_RISE;
          end
        end

        default: begin
          state_r <= WAIT_LOW;
        end
      endcase
    end
  end

  assign pos        = pos_r;
  assign pos_valid  = pos_valid_r;
  assign pos_strobe = pos_strobe_r;
  assign err        = err_r;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench for servo_pulse_decoder using scaled-down timing
// parameters and a width-to-position reference model.
module tb_servo_pulse_decoder;

  localparam int MIN  = 100;
  localparam int STEP = 2;
  localparam int GL   = 50;
  localparam int MAXC = 700;
  localparam int TO   = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pulse_in = 1'b0;
  logic [7:0] pos;
  logic       pos_valid;
  logic       pos_strobe;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

  int   cyc = 0;
  int   n_strobe = 0;
  int   n_errp = 0;
  int   n_both = 0;
  int   strobe_cyc = 0;
  int   err_cyc = 0;
  int   drop_cyc = -1;
  int   start_cyc = 0;
  logic prev_valid = 1'b0;

  servo_pulse_decoder #(
    .MIN_CYCLES(MIN), .STEP_CYCLES(STEP), .GLITCH_CYCLES(GL),
    .MAX_CYCLES(MAXC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .pos(pos),
    .pos_valid(pos_valid), .pos_strobe(pos_strobe), .err(err)
  );

  always #5 clk = ~clk;

  // Event recorder, sampled just after each active edge.
  always begin
    @(posedge clk);
    #1;
    cyc <= cyc + 1;
    if (pos_strobe) begin
      n_strobe   <= n_strobe + 1;
      strobe_cyc <= cyc + 1;
    end
    if (err) begin
      n_errp  <= n_errp + 1;
      err_cyc <= cyc + 1;
    end
    if (err && pos_strobe) n_both <= n_both + 1;
    if (prev_valid && !pos_valid) drop_cyc <= cyc + 1;
    prev_valid <= pos_valid;
  end

  // Reference decode of a high time given in clock cycles.
  function automatic int dec(input int h);
    int v;
    if (h < MIN) return 0;
    v = (h - MIN) / STEP;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic drive_pulse(input int width, input int low);
    @(negedge clk);
    pulse_in  = 1'b1;
    start_cyc = cyc;
    repeat (width) @(negedge clk);
    pulse_in = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({pos, pos_valid, pos_strobe, err} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got pos=%0d valid=%0b strobe=%0b err=%0b, want all 0",
               pos, pos_valid, pos_strobe, err);
    end
  endtask

  task automatic test_accept(input int width, input string name);
    int s0, e0;
    s0 = n_strobe; e0 = n_errp;
    drive_pulse(width, 8);
    n_vec++;
    if (n_strobe - s0 != 1 || n_errp - e0 != 0) begin
      n_bad++;
      $display("FAIL %s_events: got strobes=%0d errs=%0d, want 1 and 0",
               name, n_strobe - s0, n_errp - e0);
    end
    n_vec++;
    if (pos !== 8'(dec(width)) && pos !== 8'(dec(width - 1))) begin
      n_bad++;
      $display("FAIL %s_pos: got %0d, want %0d", name, pos, dec(width));
    end
    n_vec++;
    if (pos_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_valid: got %0b, want 1", name, pos_valid);
    end
  endtask

  task automatic test_rejects();
    int s0, e0;
    logic [7:0] p0;
    p0 = pos; s0 = n_strobe; e0 = n_errp;
    drive_pulse(30, 8);
    n_vec++;
    if (n_errp - e0 != 1 || n_strobe != s0 || pos !== p0) begin
      n_bad++;
      $display("FAIL short_reject: got errs=%0d strobes=%0d pos=%0d, want 1 0 %0d",
               n_errp - e0, n_strobe - s0, pos, p0);
    end
    e0 = n_errp;
    drive_pulse(800, 8);
    n_vec++;
    if (n_errp - e0 != 1 || n_strobe != s0 || pos !== p0) begin
      n_bad++;
      $display("FAIL long_reject: got errs=%0d strobes=%0d pos=%0d, want 1 0 %0d",
               n_errp - e0, n_strobe - s0, pos, p0);
    end
    n_vec++;
    if (err_cyc < start_cyc + MAXC + 2 || err_cyc > start_cyc + MAXC + 4) begin
      n_bad++;
      $display("FAIL long_err_time: got err at +%0d cycles, want +%0d",
               err_cyc - start_cyc, MAXC + 3);
    end
  endtask

  task automatic test_high_at_reset();
    int s0, e0;
    @(negedge clk);
    rst_n    = 1'b0;
    pulse_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = n_strobe; e0 = n_errp;
    repeat (100) @(negedge clk);
    pulse_in = 1'b0;
    repeat (8) @(negedge clk);
    n_vec++;
    if (n_strobe != s0 || n_errp != e0) begin
      n_bad++;
      $display("FAIL discard_inflight: got strobes=%0d errs=%0d, want 0 0",
               n_strobe - s0, n_errp - e0);
    end
    test_accept(355, "after_discard");
  endtask

  task automatic test_timeout();
    test_accept(355, "pre_timeout");
    drop_cyc = -1;
    repeat (TO + 20) @(negedge clk);
    n_vec++;
    if (drop_cyc - strobe_cyc != TO) begin
      n_bad++;
      $display("FAIL timeout_time: got drop %0d cycles after accept, want %0d",
               drop_cyc - strobe_cyc, TO);
    end
    n_vec++;
    if (pos_valid !== 1'b0 || pos !== 8'd127) begin
      n_bad++;
      $display("FAIL timeout_state: got valid=%0b pos=%0d, want 0 127", pos_valid, pos);
    end
    test_accept(400, "post_timeout");
  endtask

  task automatic test_reset_mid_measure();
    int s0, e0;
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({pos, pos_valid, pos_strobe, err} !== 11'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got pos=%0d valid=%0b strobe=%0b err=%0b, want 0",
               pos, pos_valid, pos_strobe, err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = n_strobe; e0 = n_errp;
    repeat (100) @(negedge clk);
    pulse_in = 1'b0;
    repeat (8) @(negedge clk);
    n_vec++;
    if (n_strobe != s0 || n_errp != e0) begin
      n_bad++;
      $display("FAIL mid_reset_truncated: got strobes=%0d errs=%0d, want 0 0",
               n_strobe - s0, n_errp - e0);
    end
  endtask

  task automatic test_random();
    int w, lo, s0, e0, exp_a, exp_b;
    exp_a = dec(355); exp_b = dec(354);
    test_accept(355, "rand_seed");
    for (int i = 0; i < 24; i++) begin
      s0 = n_strobe; e0 = n_errp;
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom_range(3, GL - 3);
        lo = $urandom_range(6, 20);
        drive_pulse(w, lo);
        n_vec++;
        if (n_errp - e0 != 1 || n_strobe != s0 ||
            (pos !== 8'(exp_a) && pos !== 8'(exp_b))) begin
          n_bad++;
          $display("FAIL rand_short w=%0d: got errs=%0d strobes=%0d pos=%0d, want 1 0 %0d",
                   w, n_errp - e0, n_strobe - s0, pos, exp_a);
        end
      end else begin
        w = $urandom_range(GL + 3, MAXC - 3);
        lo = $urandom_range(6, 20);
        drive_pulse(w, lo);
        exp_a = dec(w); exp_b = dec(w - 1);
        n_vec++;
        if (n_strobe - s0 != 1 || n_errp != e0 || pos_valid !== 1'b1 ||
            (pos !== 8'(exp_a) && pos !== 8'(exp_b))) begin
          n_bad++;
          $display("FAIL rand_accept w=%0d: got strobes=%0d errs=%0d valid=%0b pos=%0d, want 1 0 1 %0d",
                   w, n_strobe - s0, n_errp - e0, pos_valid, pos, exp_a);
        end
      end
    end
  endtask

  task automatic test_exclusive();
    n_vec++;
    if (n_both != 0) begin
      n_bad++;
      $display("FAIL err_strobe_overlap: got %0d overlapping cycles, want 0", n_both);
    end
  endtask

  initial begin
    test_reset();
    test_accept(355, "mid_pulse");
    test_accept(100, "min_pulse");
    test_accept(612, "max_pulse");
    test_accept(680, "saturated");
    test_accept(70, "sub_min");
    test_rejects();
    test_high_at_reset();
    test_timeout();
    test_reset_mid_measure();
    test_random();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/servo_pulse_decoder.md
# servo_pulse_decoder

Receive-side counterpart of the servo PWM generator. It measures the high time of an incoming RC/servo pulse train and decodes it into the same 8-bit position scale the generator drives: 1.0 ms maps to 0 and 2.0 ms maps to 255. It sits at an external pulse input, for example an RC receiver channel or loop-back from our own servo output, and feeds the position counter/arm logic on the 25 MHz system clock.

## Interface
Parameters:
- MIN_CYCLES, 25000: pulse length (clk cycles) that decodes to pos 0 (1.0 ms @ 25 MHz).
- STEP_CYCLES, 98: clk cycles per position LSB above MIN_CYCLES.
- GLITCH_CYCLES, 12500: pulses shorter than this (0.5 ms) are rejected.
- MAX_CYCLES, 62500: pulses reaching this length (2.5 ms) are rejected.
- TIMEOUT_CYCLES, 750000: with no accepted pulse for this long (30 ms), pos_valid drops.

Ports:
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- pulse_in  in  1  asynchronous servo pulse input.
- pos  out  8  last accepted decoded position.
- pos_valid  out  1  high while accepted pulses keep arriving within TIMEOUT_CYCLES.
- pos_strobe  out  1  one-cycle pulse, coincident with each pos update.
- err  out  1  one-cycle pulse per rejected pulse (too short or too long).

## Operation
- pulse_in passes through a 2-FF synchronizer, then a third register for edge detection. All counters are 20 bits.
- States:
  - WAIT_LOW (reset state): wait for the synced input to be low. This discards a pulse already in progress at reset. Go to WAIT_RISE.
  - WAIT_RISE: on a rising edge, clear hi_cnt, step_cnt and sub_cnt, then go to MEASURE.
  - MEASURE: each synced-high cycle, hi_cnt++. Once hi_cnt ≥ MIN_CYCLES, sub_cnt counts 0..STEP_CYCLES-1; on wrap, step_cnt++, saturating at 255.
    - Falling edge with hi_cnt < GLITCH_CYCLES: pulse err, pos unchanged, go to WAIT_RISE.
    - Falling edge otherwise: pos ← step_cnt, pulse pos_strobe, set pos_valid, clear the timeout counter, go to WAIT_RISE.
    - hi_cnt reaches MAX_CYCLES while still high: pulse err, go to WAIT_LOW, no update.
- Decode rule: pos = min(255, floor(max(0, hi_cnt − MIN_CYCLES) / STEP_CYCLES)). Widths between GLITCH_CYCLES and MIN_CYCLES decode to 0.
- Timeout: a free-running counter clears on each accepted pulse. At TIMEOUT_CYCLES it clears pos_valid and holds at that value; pos keeps its last value.
- Simultaneous events:
  - An accepted falling edge in the same cycle as the timeout wins: pos_valid stays 1.
  - err and pos_strobe are never high together.

## Timing
- Reset values: pos = 0, pos_valid = 0, pos_strobe = 0, err = 0. State = WAIT_LOW; all counters and the synchronizer are 0.
- rst_n assertion clears everything immediately, including mid-pulse. After release, no update occurs until a full low→high→low pulse is observed.
- Latency: pos, pos_strobe and err register 3 clk edges after the first edge that samples pulse_in low.
- hi_cnt equals the pin high time in clk cycles, ±1 for asynchronous input alignment.
- Minimum input low time between pulses: 2 cycles. Shorter lows may be missed; this is not an error.
- Update rate equals the input frame rate (typically 20 ms). There is no back-pressure; the consumer samples on pos_strobe.

## Test plan
- Reset, then one 37500-cycle pulse: pos = 127, one pos_strobe, pos_valid = 1, err = 0.
- Pulses of 25000 and 50000 cycles: pos = 0, then pos = 255. A 60000-cycle pulse gives pos = 255 (saturated), no err.
- 7500-cycle pulse, then 65000-cycle pulse: err pulses twice. For the long pulse, err fires when hi_cnt = 62500, not at the fall. pos is unchanged, and no decode happens on that long pulse's falling edge.
- Input held high across rst_n release, falls after 10000 cycles, then a 37500-cycle pulse: only the second pulse updates pos (127).
- Valid 1.5 ms pulse, then input held low: pos_valid drops exactly TIMEOUT_CYCLES after the accept, pos stays 127. The next valid pulse restores pos_valid = 1.
- rst_n asserted mid-MEASURE (hi_cnt ≈ 30000): outputs return to reset values immediately, and no strobe occurs for the truncated pulse.
